// File: rtl/time_field_counter.sv
// rtl/time_field_counter.sv - modulo-N BCD clock field with tick, carry and key edit
//
// One field of a chained clock (seconds, minutes, hours, ...). Counts 0..MODULO-1
// on tick, pulses carry on the wrap to 0, and lets the user edit the units or
// tens digit with active-low plus/minus keys (edge detected on chip).
//
// Optional feature macro: TFC_DOWN_EN (adds dir input and borrow output).
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-low reset
//   tick         advance request, one count per high cycle
//   edit_en      1 = edit mode: ticks ignored, keys active
//   digit_sel    0 = edit units digit, 1 = edit tens digit
//   key_plus_n   active-low plus key, raw level
//   key_minus_n  active-low minus key, raw level
//   load         synchronous load strobe
//   load_value   value to load (clamped to MODULO-1)
//   dir          (TFC_DOWN_EN) 1 = tick decrements
//   borrow       (TFC_DOWN_EN) one-cycle pulse on down wrap 0 -> MODULO-1
//   count        current field value
//   units        count % 10, BCD
//   tens         count / 10, BCD
//   carry        one-cycle pulse on up wrap MODULO-1 -> 0

module time_field_counter #(
  parameter int MODULO = 60,
  parameter int WIDTH  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             edit_en,
  input  logic             digit_sel,
  input  logic             key_plus_n,
  input  logic             key_minus_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef TFC_DOWN_EN
  input  logic             dir,
  output logic             borrow,
`endif
  output logic [WIDTH-1:0] count,
  output logic [3:0]       units,
  output logic [3:0]       tens,
  output logic             carry
);

  localparam int               TMAX     = (MODULO - 1) / 10;
  localparam int               UMAX_TOP = (MODULO - 1) % 10;
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MODULO - 1);

  logic             plus_prev;
  logic             minus_prev;
  logic             plus_ev;
  logic             minus_ev;
  logic [WIDTH-1:0] load_next;
  logic [WIDTH-1:0] edit_next;
  int               ed_u;
  int               ed_t;
  int               ed_umax;
  int               ed_v;

  // Press event: key low now, high on the previous sampled cycle.
  assign plus_ev  = plus_prev  & ~key_plus_n;
  assign minus_ev = minus_prev & ~key_minus_n;

  assign load_next = (int'(load_value) < MODULO) ? load_value : MAXV;

  always_comb begin
    units = 4'(int'(count) % 10);
    tens  = 4'(int'(count) / 10);
  end

  // Digit edit: wrap the chosen digit within its legal range, then clamp the
  // recombined value, since a tens change can push it past MODULO-1.
  always_comb begin
    ed_u    = int'(count) % 10;
    ed_t    = int'(count) / 10;
    ed_umax = (ed_t == TMAX) ? UMAX_TOP : 9;
    if (!digit_sel) begin
      if (plus_ev) ed_u = (ed_u == ed_umax) ? 0 : ed_u + 1;
      else         ed_u = (ed_u == 0) ? ed_umax : ed_u - 1;
    end else begin
      if (plus_ev) ed_t = (ed_t == TMAX) ? 0 : ed_t + 1;
      else         ed_t = (ed_t == 0) ? TMAX : ed_t - 1;
    end
    ed_v = ed_t * 10 + ed_u;
    if (ed_v > MODULO - 1) ed_v = MODULO - 1;
    // No event, or both keys at once, leaves the field untouched.
    edit_next = (plus_ev ^ minus_ev) ? WIDTH'(ed_v) : count;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= '0;
      carry      <= 1'b0;
      plus_prev  <= 1'b1;
      minus_prev <= 1'b1;
`ifdef TFC_DOWN_EN
      borrow     <= 1'b0;
`endif
    end else begin
      // Key history tracks every cycle, so leaving edit mode mid-press
      // cannot manufacture an event later.
      plus_prev  <= key_plus_n;
      minus_prev <= key_minus_n;
      carry      <= 1'b0;
`ifdef TFC_DOWN_EN
      borrow     <= 1'b0;
`endif
      if (load) begin
        count <= load_next;
      end else if (tick && !edit_en) begin
`ifdef TFC_DOWN_EN
        if (dir) begin
          if (count == '0) begin
            count  <= MAXV;
            borrow <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end else
`endif
        if (count == MAXV) begin
          count <= '0;
          carry <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (edit_en) begin
        count <= edit_next;
      end
    end
  end

endmodule

// File: tb/tb_time_field_counter.sv
// tb/tb_time_field_counter.sv - directed vector bench for time_field_counter

module tb_time_field_counter;

  logic       clk = 1'b0;
  logic       reset, tick, edit_en, digit_sel, key_plus_n, key_minus_n, load;
  logic [6:0] load_value;
  logic [6:0] count60;
  logic [3:0] units60, tens60;
  logic       carry60;
  logic [4:0] count24;
  logic [3:0] units24, tens24;
  logic       carry24;
`ifdef TFC_DOWN_EN
  logic       dir = 1'b0;
  logic       borrow60, borrow24;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  time_field_counter #(.MODULO(60), .WIDTH(7)) dut60 (
    .clk(clk), .reset(reset), .tick(tick), .edit_en(edit_en), .digit_sel(digit_sel),
    .key_plus_n(key_plus_n), .key_minus_n(key_minus_n), .load(load),
    .load_value(load_value),
`ifdef TFC_DOWN_EN
    .dir(dir), .borrow(borrow60),
`endif
    .count(count60), .units(units60), .tens(tens60), .carry(carry60)
  );

  time_field_counter #(.MODULO(24), .WIDTH(5)) dut24 (
    .clk(clk), .reset(reset), .tick(tick), .edit_en(edit_en), .digit_sel(digit_sel),
    .key_plus_n(key_plus_n), .key_minus_n(key_minus_n), .load(load),
    .load_value(load_value[4:0]),
`ifdef TFC_DOWN_EN
    .dir(dir), .borrow(borrow24),
`endif
    .count(count24), .units(units24), .tens(tens24), .carry(carry24)
  );

  typedef struct {
    logic rst, tk, ed, ds, kp, km, ld;
    int   lv;
    int   d;     // 0 = check MODULO 60 instance, 1 = MODULO 24 instance
    int   ec;
    int   ecy;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    reset = v.rst; tick = v.tk; edit_en = v.ed; digit_sel = v.ds;
    key_plus_n = v.kp; key_minus_n = v.km; load = v.ld; load_value = 7'(v.lv);
    @(posedge clk);
    #1;
    if (v.d == 0) begin
      chk({nm, " count"}, int'(count60), v.ec);
      chk({nm, " units"}, int'(units60), v.ec % 10);
      chk({nm, " tens"},  int'(tens60),  v.ec / 10);
      chk({nm, " carry"}, int'(carry60), v.ecy);
    end else begin
      chk({nm, " count24"}, int'(count24), v.ec);
      chk({nm, " units24"}, int'(units24), v.ec % 10);
      chk({nm, " tens24"},  int'(tens24),  v.ec / 10);
      chk({nm, " carry24"}, int'(carry24), v.ecy);
    end
  endtask

  //                     rst  tk   ed   ds   kp   km   ld   lv  d  ec  ecy
  task automatic addv(input logic rst, tk, ed, ds, kp, km, ld, input int lv, d, ec, ecy);
    vt.push_back('{rst, tk, ed, ds, kp, km, ld, lv, d, ec, ecy});
  endtask

  vec_t v;

  initial begin
    reset = 0; tick = 0; edit_en = 0; digit_sel = 0;
    key_plus_n = 1; key_minus_n = 1; load = 0; load_value = 0;

    // reset
    addv(0, 0, 0, 0, 1, 1, 0,  0, 0,  0, 0);
    addv(0, 0, 0, 0, 1, 1, 0,  0, 1,  0, 0);
    // units edit on 60: load 29, held plus gives one event, minus wraps back
    addv(1, 0, 1, 0, 1, 1, 1, 29, 0, 29, 0);
    addv(1, 0, 1, 0, 0, 1, 0,  0, 0, 20, 0);
    addv(1, 0, 1, 0, 0, 1, 0,  0, 0, 20, 0);
    addv(1, 0, 1, 0, 0, 1, 0,  0, 0, 20, 0);
    addv(1, 0, 1, 0, 0, 1, 0,  0, 0, 20, 0);
    addv(1, 0, 1, 0, 0, 1, 0,  0, 0, 20, 0);
    addv(1, 0, 1, 0, 1, 1, 0,  0, 0, 20, 0);
    addv(1, 0, 1, 0, 1, 0, 0,  0, 0, 29, 0);
    addv(1, 0, 1, 0, 1, 1, 0,  0, 0, 29, 0);
    // load clamp, both keys at once, load beats tick, then wrap carry
    addv(1, 0, 1, 0, 1, 1, 1, 99, 0, 59, 0);
    addv(1, 0, 1, 0, 0, 0, 0,  0, 0, 59, 0);
    addv(1, 0, 1, 0, 1, 1, 0,  0, 0, 59, 0);
    addv(1, 1, 0, 0, 1, 1, 1, 59, 0, 59, 0);
    addv(1, 1, 0, 0, 1, 1, 0,  0, 0,  0, 1);
    addv(1, 0, 0, 0, 1, 1, 0,  0, 0,  0, 0);
    // tens edit with clamp on 24
    addv(1, 0, 1, 1, 1, 1, 1,  5, 1,  5, 0);
    addv(1, 0, 1, 1, 1, 0, 0,  0, 1, 23, 0);
    addv(1, 0, 1, 1, 1, 1, 0,  0, 1, 23, 0);
    addv(1, 0, 1, 1, 0, 1, 0,  0, 1,  3, 0);
    addv(1, 0, 1, 1, 1, 1, 0,  0, 1,  3, 0);
    addv(1, 0, 0, 0, 1, 1, 1, 30, 1, 23, 0);
    // units edit at top tens on 24: units range 0..3
    addv(1, 0, 1, 0, 0, 1, 0,  0, 1, 20, 0);
    addv(1, 0, 1, 0, 1, 1, 0,  0, 1, 20, 0);
    addv(1, 0, 1, 0, 1, 0, 0,  0, 1, 23, 0);
    addv(1, 0, 1, 0, 1, 1, 0,  0, 1, 23, 0);

    foreach (vt[i]) step(vt[i], $sformatf("vec%0d", i));

    // reset then a full 60-tick revolution with a single carry at count 0
    step('{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0}, "rst_a");
    step('{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0}, "rst_b");
    for (int i = 1; i <= 60; i++)
      step('{1, 1, 0, 0, 1, 1, 0, 0, 0, i % 60, (i == 60) ? 1 : 0}, $sformatf("tick%0d", i));
    step('{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0}, "tick_idle");

    // ticks ignored in edit mode
    step('{1, 0, 0, 0, 1, 1, 1, 37, 0, 37, 0}, "ign_load");
    for (int i = 0; i < 10; i++)
      step('{1, 1, 1, 0, 1, 1, 0, 0, 0, 37, 0}, $sformatf("ign%0d", i));

    // reset mid-edit while plus key held
    step('{1, 0, 1, 0, 0, 1, 1, 45, 0, 45, 0}, "me_load");
    step('{1, 0, 1, 0, 0, 1, 0, 0, 0, 45, 0}, "me_hold");
    step('{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0}, "me_rst");
    step('{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0}, "me_noedit");
    for (int i = 0; i < 3; i++)
      step('{1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0}, $sformatf("me_held%0d", i));
    step('{1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0}, "me_rel");
    step('{1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0}, "me_repress");
    step('{1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0}, "me_rel2");

`ifdef TFC_DOWN_EN
    // down mode: wrap 0 -> 59 with borrow, no carry
    step('{1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0}, "dn_load");
    chk("dn_borrow0", int'(borrow60), 0);
    dir = 1'b1;
    step('{1, 1, 0, 0, 1, 1, 0, 0, 0, 59, 0}, "dn_wrap");
    chk("dn_borrow1", int'(borrow60), 1);
    step('{1, 1, 0, 0, 1, 1, 0, 0, 0, 58, 0}, "dn_dec");
    chk("dn_borrow2", int'(borrow60), 0);
    dir = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
